// File: rtl/seg_scan_arbiter.sv
// Two-requester ownership arbiter for an 8-digit multiplexed 7-segment display.
// Ownership changes only at frame boundaries, with bounded hold when contested.
module seg_scan_arbiter #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [55:0] frame_a,
    input  logic [55:0] frame_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [7:0]  com,
    output logic [6:0]  Segout,
    output logic        frame_done
);

    localparam int unsigned PW        = $clog2(SCAN_DIV);
    localparam int unsigned HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int unsigned HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_lp;      // last owner: 0 = A, 1 = B
    logic [PW-1:0]   r_presc;
    logic [2:0]      r_idx;
    logic [HW-1:0]   r_hold;

    logic [6:0]      w_dig_a [8];
    logic [6:0]      w_dig_b [8];
    logic            w_tick;
    logic            w_boundary;
    logic            w_owned;
    logic            w_req_own;
    logic            w_req_oth;
    state_t          w_other;
    logic [6:0]      w_digit;

    // Digit slicing, scan timing and owner-relative request view
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_dig_a[k] = frame_a[7*k +: 7];
            w_dig_b[k] = frame_b[7*k +: 7];
        end
        w_tick     = (r_presc == PW'(SCAN_DIV - 1));
        w_boundary = w_tick && (r_idx == 3'd7);
        w_owned    = (r_state != S_IDLE);
        w_req_own  = (r_state == S_OWN_B) ? req_b : req_a;
        w_req_oth  = (r_state == S_OWN_B) ? req_a : req_b;
        w_other    = (r_state == S_OWN_A) ? S_OWN_B : S_OWN_A;
        w_digit    = (r_state == S_OWN_B) ? w_dig_b[r_idx] : w_dig_a[r_idx];
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_lp       <= 1'b1;
            r_presc    <= '0;
            r_idx      <= '0;
            r_hold     <= '0;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            com        <= 8'hFF;
            Segout     <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            // Display drive lags the scan position by one cycle
            com        <= w_owned ? ~(8'd1 << r_idx) : 8'hFF;
            Segout     <= w_owned ? w_digit : 7'h00;
            frame_done <= w_owned && w_boundary;

            case (r_state)
                S_IDLE: begin
                    if (req_a || req_b) begin
                        r_presc <= '0;
                        r_idx   <= '0;
                        r_hold  <= '0;
                        if (req_a && (!req_b || r_lp)) begin
                            r_state <= S_OWN_A;
                            gnt_a   <= 1'b1;
                            gnt_b   <= 1'b0;
                            r_lp    <= 1'b0;
                        end else begin
                            r_state <= S_OWN_B;
                            gnt_a   <= 1'b0;
                            gnt_b   <= 1'b1;
                            r_lp    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_presc <= w_tick ? '0 : r_presc + PW'(1);
                    if (w_tick) begin
                        r_idx <= r_idx + 3'd1;
                    end
                    if (w_boundary) begin
                        if (!w_req_own) begin
                            r_hold <= '0;
                            if (w_req_oth) begin
                                r_state <= w_other;
                                gnt_a   <= (w_other == S_OWN_A);
                                gnt_b   <= (w_other == S_OWN_B);
                                r_lp    <= (w_other == S_OWN_B);
                            end else begin
                                r_state <= S_IDLE;
                                gnt_a   <= 1'b0;
                                gnt_b   <= 1'b0;
                            end
                        end else if (w_req_oth) begin
                            // Contested: preempt once the owner has held long enough
                            if ((MAX_HOLD != 0) && (r_hold == HW'(HOLD_LAST))) begin
                                r_hold  <= '0;
                                r_state <= w_other;
                                gnt_a   <= (w_other == S_OWN_A);
                                gnt_b   <= (w_other == S_OWN_B);
                                r_lp    <= (w_other == S_OWN_B);
                            end else if (MAX_HOLD != 0) begin
                                r_hold <= r_hold + HW'(1);
                            end
                        end else begin
                            r_hold <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule
